// File: rtl/pipe_elastic_chain.sv
// pipe_elastic_chain
//   Bubble-collapsing elastic pipeline of DEPTH register slots. Slot 0 is the
//   input side and slot DEPTH-1 drives the output. Items move forward whenever
//   the next slot is empty or itself advancing. A global stall freezes the
//   whole chain, and a masked flush squashes selected slots.
//
// Ports
//   clock        rising-edge clock
//   reset_n      synchronous active-low reset
//   in_valid     upstream item offered
//   in_ready     slot 0 can accept this cycle (combinational from out_ready)
//   in_data      upstream payload
//   out_valid    slot DEPTH-1 holds an item and the chain is not stalled
//   out_ready    downstream accepts
//   out_data     payload of slot DEPTH-1
//   stall        global freeze: no slot advances, no handshake completes
//   flush        squash request, qualified by flush_mask
//   flush_mask   bit i=1: clear slot i on this edge when flush=1
//   stage_valid  valid bit per slot
//   stage_data   slot i payload at [i*DATA_WIDTH +: DATA_WIDTH]
//   occupancy    number of valid slots (registered)

module pipe_elastic_chain #(
  parameter int DEPTH      = 5,
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = $clog2(DEPTH + 1)
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [DATA_WIDTH-1:0]       in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DATA_WIDTH-1:0]       out_data,
  input  logic                        stall,
  input  logic                        flush,
  input  logic [DEPTH-1:0]            flush_mask,
  output logic [DEPTH-1:0]            stage_valid,
  output logic [DEPTH*DATA_WIDTH-1:0] stage_data,
  output logic [CNT_WIDTH-1:0]        occupancy
);

  logic [DEPTH-1:0]      valid_r;
  logic [DATA_WIDTH-1:0] data_r [DEPTH];
  logic [CNT_WIDTH-1:0]  occ_r;

  logic [DEPTH-1:0]      adv_s;
  logic [DEPTH-1:0]      load_s;
  logic [DEPTH-1:0]      capture_s;
  logic [DEPTH-1:0]      valid_nxt_s;
  logic [CNT_WIDTH-1:0]  occ_nxt_s;
  logic                  accept_s;

  // Number of set bits in a slot-valid vector.
  function automatic logic [CNT_WIDTH-1:0] popcount(input logic [DEPTH-1:0] v);
    logic [CNT_WIDTH-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      cnt = cnt + CNT_WIDTH'(v[i]);
    end
    return cnt;
  endfunction

  // Advance chain, output end first: a slot moves when the slot ahead is free
  // or itself moving. The local "ahead_free" carries that condition downward.
  always_comb begin
    logic ahead_free;
    logic a;
    adv_s      = '0;
    ahead_free = out_ready;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      a          = valid_r[i] & ahead_free & ~stall;
      adv_s[i]   = a;
      ahead_free = ~valid_r[i] | a;
    end
  end

  assign in_ready  = reset_n & ~stall & (~valid_r[0] | adv_s[0]);
  assign accept_s  = in_valid & in_ready;
  assign out_valid = reset_n & valid_r[DEPTH-1] & ~stall;
  assign out_data  = data_r[DEPTH-1];

  // Next valid vector: load beats drain, then the flush mask clears slots
  // even if they are receiving an item (that item is squashed).
  always_comb begin
    load_s    = '0;
    capture_s = '0;
    load_s[0] = accept_s;
    for (int i = 1; i < DEPTH; i++) begin
      load_s[i] = adv_s[i-1];
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (load_s[i]) begin
        capture_s[i] = 1'b1;
      end else if (adv_s[i]) begin
        capture_s[i] = 1'b0;
      end else begin
        capture_s[i] = valid_r[i];
      end
    end
    valid_nxt_s = flush ? (capture_s & ~flush_mask) : capture_s;
    occ_nxt_s   = popcount(valid_nxt_s);
  end

  // Slot state: valid bits, payloads and occupancy, synchronous reset.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      valid_r <= '0;
      occ_r   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_r[i] <= '0;
      end
    end else begin
      valid_r <= valid_nxt_s;
      occ_r   <= occ_nxt_s;
      if (load_s[0]) begin
        data_r[0] <= in_data;
      end
      for (int i = 1; i < DEPTH; i++) begin
        if (load_s[i]) begin
          data_r[i] <= data_r[i-1];
        end
      end
    end
  end

  // Flatten slot payloads onto the observation bus.
  always_comb begin
    stage_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      stage_data[i*DATA_WIDTH +: DATA_WIDTH] = data_r[i];
    end
  end

  assign stage_valid = valid_r;
  assign occupancy   = occ_r;

endmodule

// File: tb/tb_pipe_elastic_chain.sv
`timescale 1ns/1ps
module tb_pipe_elastic_chain;

  localparam int DEPTH      = 5;
  localparam int DATA_WIDTH = 32;
  localparam int CNT_WIDTH  = $clog2(DEPTH + 1);

  logic                        clock;
  logic                        reset_n;
  logic                        in_valid;
  logic                        in_ready;
  logic [DATA_WIDTH-1:0]       in_data;
  logic                        out_valid;
  logic                        out_ready;
  logic [DATA_WIDTH-1:0]       out_data;
  logic                        stall;
  logic                        flush;
  logic [DEPTH-1:0]            flush_mask;
  logic [DEPTH-1:0]            stage_valid;
  logic [DEPTH*DATA_WIDTH-1:0] stage_data;
  logic [CNT_WIDTH-1:0]        occupancy;

  int n_cmp;
  int n_err;

  pipe_elastic_chain #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .stall       (stall),
    .flush       (flush),
    .flush_mask  (flush_mask),
    .stage_valid (stage_valid),
    .stage_data  (stage_data),
    .occupancy   (occupancy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DATA_WIDTH-1:0] slot(input int i);
    return stage_data[i*DATA_WIDTH +: DATA_WIDTH];
  endfunction

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid   = 1'b0;
    in_data    = 32'h0;
    out_ready  = 1'b0;
    stall      = 1'b0;
    flush      = 1'b0;
    flush_mask = 5'b00000;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset_n = 1'b0;
    cyc();
    reset_n = 1'b1;
  endtask

  // Push 5 items base..base+4 into an empty chain with out_ready=0;
  // afterwards slot 4 holds base and slot 0 holds base+4.
  task automatic fill(input logic [31:0] base);
    for (int k = 0; k < 5; k++) begin
      in_valid  = 1'b1;
      in_data   = base + 32'(k);
      out_ready = 1'b0;
      cyc();
    end
    in_valid = 1'b0;
  endtask

  initial begin
    int n;
    int acc;
    int del;
    n_cmp   = 0;
    n_err   = 0;
    reset_n = 1'b0;
    idle_inputs();

    // Reset state
    #1;
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    cyc();
    reset_n = 1'b1;
    #1;
    chk("rst_stage_valid", stage_valid, 5'b00000);
    chk("rst_occ", occupancy, 3'd0);
    chk("rst_out_valid2", out_valid, 1'b0);

    // Streaming: 0x100..0x109, out_ready=1
    for (int c = 0; c < 16; c++) begin
      in_valid  = (c < 10);
      in_data   = 32'h100 + 32'(c);
      out_ready = 1'b1;
      #1;
      chk("stream_in_ready", in_ready, 1'b1);
      chk("stream_out_valid", out_valid, (c >= 5 && c < 15));
      if (c >= 5 && c < 15) chk("stream_out_data", out_data, 32'h100 + 32'(c - 5));
      acc = (c < 10) ? c : 10;
      del = (c <= 5) ? 0 : ((c - 5 > 10) ? 10 : c - 5);
      chk("stream_occ", occupancy, 64'(acc - del));
      cyc();
    end

    // Backpressure: out_ready=0, offer 7 items
    do_reset();
    n = 0;
    for (int c = 0; c < 8; c++) begin
      in_valid  = (n < 7);
      in_data   = 32'h100 + 32'(n);
      out_ready = 1'b0;
      #1;
      chk("bp_in_ready", in_ready, (c < 5));
      if (c < 5) n++;
      cyc();
    end
    #1;
    chk("bp_occ", occupancy, 3'd5);
    chk("bp_stage_valid", stage_valid, 5'b11111);
    chk("bp_out_valid", out_valid, 1'b1);
    for (int j = 0; j < 8; j++) begin
      out_ready = 1'b1;
      in_valid  = (j < 2);
      in_data   = 32'h105 + 32'(j);
      #1;
      if (j == 0) chk("bp_release_in_ready", in_ready, 1'b1);
      chk("bp_out_valid_seq", out_valid, (j < 7));
      if (j < 7) chk("bp_out_data_seq", out_data, 32'h100 + 32'(j));
      cyc();
    end

    // Single item collapses to the output slot
    do_reset();
    in_valid = 1'b1;
    in_data  = 32'hA5;
    cyc();
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) cyc();
    #1;
    chk("single_stage_valid", stage_valid, 5'b10000);
    chk("single_occ", occupancy, 3'd1);
    chk("single_slot4", slot(4), 32'hA5);
    chk("single_out_valid", out_valid, 1'b1);

    // Stall on a full chain
    do_reset();
    fill(32'h1);
    stall     = 1'b1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 32'h6;
    for (int s = 0; s < 3; s++) begin
      #1;
      chk("stall_out_valid", out_valid, 1'b0);
      chk("stall_in_ready", in_ready, 1'b0);
      for (int i = 0; i < DEPTH; i++) chk("stall_slot", slot(i), 32'(5 - i));
      chk("stall_occ", occupancy, 3'd5);
      cyc();
    end
    stall = 1'b0;
    #1;
    chk("unstall_out_valid", out_valid, 1'b1);
    chk("unstall_out_data", out_data, 32'h1);
    chk("unstall_in_ready", in_ready, 1'b1);
    cyc();
    in_valid = 1'b0;
    #1;
    chk("unstall_next_data", out_data, 32'h2);

    // Flush lower slots, output blocked
    do_reset();
    fill(32'h1);
    flush      = 1'b1;
    flush_mask = 5'b00111;
    out_ready  = 1'b0;
    cyc();
    flush = 1'b0;
    #1;
    chk("flush_stage_valid", stage_valid, 5'b11000);
    chk("flush_occ", occupancy, 3'd2);
    chk("flush_slot4", slot(4), 32'h1);
    chk("flush_slot3", slot(3), 32'h2);

    // Flush lower slots while draining: slot 2 item survives into slot 3
    do_reset();
    fill(32'h1);
    flush      = 1'b1;
    flush_mask = 5'b00111;
    out_ready  = 1'b1;
    #1;
    chk("flushmv_out_valid", out_valid, 1'b1);
    chk("flushmv_out_data", out_data, 32'h1);
    cyc();
    flush     = 1'b0;
    out_ready = 1'b0;
    #1;
    chk("flushmv_stage_valid", stage_valid, 5'b11000);
    chk("flushmv_occ", occupancy, 3'd2);
    chk("flushmv_slot4", slot(4), 32'h2);
    chk("flushmv_slot3", slot(3), 32'h3);

    // Flush beats stall
    do_reset();
    fill(32'h1);
    stall      = 1'b1;
    flush      = 1'b1;
    flush_mask = 5'b10001;
    out_ready  = 1'b1;
    cyc();
    stall     = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
    #1;
    chk("flushstall_stage_valid", stage_valid, 5'b01110);
    chk("flushstall_occ", occupancy, 3'd3);
    chk("flushstall_slot3", slot(3), 32'h2);

    // Input accepted under flush_mask[0] is discarded
    do_reset();
    in_valid   = 1'b1;
    in_data    = 32'h55;
    flush      = 1'b1;
    flush_mask = 5'b00001;
    #1;
    chk("flushin_in_ready", in_ready, 1'b1);
    cyc();
    idle_inputs();
    #1;
    chk("flushin_stage_valid", stage_valid, 5'b00000);
    chk("flushin_occ", occupancy, 3'd0);

    // Reset while full with input offered
    do_reset();
    fill(32'h1);
    reset_n   = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h9;
    out_ready = 1'b1;
    #1;
    chk("midrst_in_ready", in_ready, 1'b0);
    chk("midrst_out_valid", out_valid, 1'b0);
    cyc();
    reset_n  = 1'b1;
    in_valid = 1'b0;
    #1;
    chk("midrst_stage_valid", stage_valid, 5'b00000);
    chk("midrst_occ", occupancy, 3'd0);
    chk("midrst_out_valid2", out_valid, 1'b0);
    in_valid = 1'b1;
    in_data  = 32'h77;
    #1;
    chk("midrst_push_ready", in_ready, 1'b1);
    cyc();
    in_valid = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      #1;
      chk("midrst_lat_valid", out_valid, (c == 5));
      if (c == 5) chk("midrst_lat_data", out_data, 32'h77);
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pipe_elastic_chain.md
Name: pipe_elastic_chain

Overview:
- Parametrised, bubble-collapsing elastic pipeline of DEPTH register slots with valid/ready handshakes, global stall and per-slot selective flush.
- Generalises the fixed IF/ID/EX/MEM/WB pipeline-register chain so that stages can stall, squash wrong-path instructions and drain independently.
- Exposes per-slot valid/data for hazard detection and forwarding logic in the core.

Parameters:
DEPTH, 5, number of register slots (>=1); slot 0 is the input side, slot DEPTH-1 drives the output.
DATA_WIDTH, 32, payload width per slot (>=1).
CNT_WIDTH, $clog2(DEPTH+1), occupancy counter width (derived; not overridden).

Ports:
clock  in  1  rising-edge clock
reset_n  in  1  synchronous active-low reset
in_valid  in  1  upstream item offered
in_ready  out  1  slot 0 can accept this cycle
in_data  in  DATA_WIDTH  upstream payload
out_valid  out  1  slot DEPTH-1 holds an item and the chain is not stalled
out_ready  in  1  downstream accepts
out_data  out  DATA_WIDTH  payload of slot DEPTH-1
stall  in  1  global freeze: no slot advances, no handshake completes
flush  in  1  squash request, qualified by flush_mask
flush_mask  in  DEPTH  bit i=1: clear slot i on this edge when flush=1
stage_valid  out  DEPTH  valid bit per slot
stage_data  out  DEPTH*DATA_WIDTH  slot i payload at bits [i*DATA_WIDTH +: DATA_WIDTH]
occupancy  out  CNT_WIDTH  number of valid slots (registered)

Behaviour:
- Reset is synchronous: with reset_n=0 at a rising edge, all valid bits, data regs and occupancy go to 0. Reset overrides every other input, including mid-transfer; in-flight items are lost. out_valid and in_ready evaluate to 0 while in reset.
- Advance rule (combinational, computed from DEPTH-1 down to 0):
  - adv[DEPTH-1] = valid[DEPTH-1] & out_ready & !stall.
  - adv[i] = valid[i] & (!valid[i+1] | adv[i+1]) & !stall.
  - Slot i loads from slot i-1 when adv[i-1]; slot 0 loads in_data when in_valid & in_ready.
  - A slot that advances and receives nothing goes invalid. A non-advancing valid slot holds its data.
- in_ready = !stall & (!valid[0] | adv[0]). It is combinational from out_ready through the chain; there is no skid buffer. out_valid = valid[DEPTH-1] & !stall. out_data = data[DEPTH-1].
- Bubbles collapse: an item moves forward every cycle the next slot is empty or advancing, even when out_ready=0.
- Latency: an item accepted in cycle k appears on out_valid in cycle k+DEPTH if unblocked.
- Throughput: 1 item/cycle with out_ready=1 and stall=0.
- Flush, evaluated after advance:
  - When flush=1, every slot i with flush_mask[i]=1 has its next valid forced to 0, regardless of whether it is receiving an item.
  - An item leaving a flushed slot into an unflushed slot survives.
  - An input accepted while flush_mask[0]=1 completes its handshake but is discarded.
  - An output taken while flush_mask[DEPTH-1]=1 is still delivered, because the handshake already occurred.
- Flush beats stall: masked slots are cleared even while stall=1.
- Data regs load only on valid capture; flushed slots keep stale data, which is don't-care.
- Occupancy:
  - Next value = popcount of next valid vector, registered alongside the valid bits, so it always equals popcount(stage_valid).
  - Range 0..DEPTH; it cannot wrap.
- Full chain: in_ready=0 unless adv[0]. Empty chain: out_valid=0, occupancy=0. The simultaneous accept and deliver case is covered by the advance rule.
- DEPTH=1 degenerates to a single register: in_ready = !stall & (!valid[0] | out_ready).

Test Plan:
- DEPTH=5, WIDTH=32, out_ready=1: push 0x100..0x109 on consecutive cycles -> out_data emits 0x100..0x109 in order, first in cycle 5 after the first accept, one per cycle; occupancy saturates at 5.
- out_ready=0, push 7 items -> first 5 accepted, in_ready=0 from then on, occupancy=5. Raise out_ready -> 0x100..0x104 emerge back-to-back, in_ready rises the same cycle.
- Single item 0xA5 in an empty chain with out_ready=0, stall=0 -> after 5 cycles it sits in slot 4, stage_valid=5'b10000, occupancy=1.
- Full chain 0x1..0x5 (slot 4=0x1), stall=1 for 3 cycles with out_ready=1 and in_valid=1 -> no outputs, in_ready=0, stage_data unchanged. Release -> 0x1 delivered on the next cycle.
- Full chain, flush=1 with flush_mask=5'b00111 and out_ready=0 -> next cycle stage_valid=5'b11000, occupancy=2. Repeat with out_ready=1 -> slot 2 item survives into slot 3.
- reset_n=0 for one edge while full and in_valid=1 -> next cycle stage_valid=0, occupancy=0, out_valid=0. First push after release exits DEPTH cycles later.
